root_newton_param: RTL

ROOT_NEWTON_PARAM -- requirements
Module: root_newton_param

---
 rtl/root_newton_param_if.sv | 19 +
 rtl/root_newton_param.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/root_newton_param_if.sv
// Request/result bundle for root_newton_param. Signal prefixes are from the
// datapath's point of view: i_* flow into the block, o_* flow out of it.
interface root_newton_param_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_mode;
    logic [WIDTH-1:0] i_d;
    logic [WIDTH-1:0] o_q;
    logic             o_busy;
    logic             o_ready;
    logic             o_err;
    logic [2:0]       o_count;

    modport master (output i_start, i_mode, i_d,
                    input  o_q, o_busy, o_ready, o_err, o_count);
    modport slave  (input  i_start, i_mode, i_d,
                    output o_q, o_busy, o_ready, o_err, o_count);
endinterface

// File: rtl/root_newton_param.sv
// Iterative Newton-Raphson sqrt(d) / 1/sqrt(d) for a U0.WIDTH operand in [0.25, 1).
// Optional macro ROOT_NEWTON_ROUND_EN: round-to-nearest (2 guard bits) with saturation in FINAL.
module root_newton_param #(
    parameter int WIDTH     = 32,
    parameter int ITERS     = 3,
    parameter int SEED_BITS = 4
) (
    input logic                i_clk,
    input logic                i_reset,
    root_newton_param_if.slave bus
);
    localparam int F     = WIDTH + 2;   // fraction bits of x (x is U2.F)
    localparam int IW    = F + 2;
    localparam int PW    = 2 * IW;
    localparam int P     = 16;          // seed table precision
    localparam int TB    = 8;           // operand bits used to interpolate inside a seed interval
    localparam int NSEED = 1 << SEED_BITS;
    localparam int KMIN  = 1 << (SEED_BITS - 2);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINAL, S_DONE} state_t;

    function automatic logic [63:0] isqrt(input logic [63:0] v);
        logic [63:0] r;
        logic [63:0] b;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            b = r | (64'd1 << i);
            if (b * b <= v) r = b;
        end
        return r;
    endfunction

    // 1/sqrt(k / 2^SEED_BITS) as U2.P
    function automatic logic [P+1:0] rsq(input int k);
        logic [63:0] num;
        num = 64'd1 << (2 * P + SEED_BITS);
        return (P+2)'(isqrt(num / 64'(k)));
    endfunction

    // Each entry holds rsqrt at the interval's low edge and the drop across it,
    // so the seed is a chord; the low edge is exact, which keeps d=0.25 exact.
    logic [P+1:0] w_seed_a  [NSEED];
    logic [P-1:0] w_seed_dl [NSEED];
    for (genvar g = 0; g < NSEED; g++) begin : g_seed
        localparam int           K  = (g < KMIN) ? KMIN : g;
        localparam logic [P+1:0] A  = rsq(K);
        localparam logic [P+1:0] DL = rsq(K) - rsq(K + 1);
        assign w_seed_a[g]  = A;
        assign w_seed_dl[g] = DL[P-1:0];
    end

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_d, r_q, w_q;
    logic [IW-1:0]    r_x, w_x0, w_dx, w_dxx, w_h, w_xn;
    logic [PW-1:0]    w_p_dx, w_p_dxx, w_p_xh, w_g0;
    logic [P+TB-1:0]  w_drop;
    logic [P+1:0]     w_x0p;
    logic [WIDTH+1:0] w_g;
    logic [2:0]       r_count;
    logic             r_mode, r_err, w_ovf, w_inrange, w_accept;
    logic [SEED_BITS-1:0] w_idx;
    logic [TB-1:0]    w_t;

    assign w_inrange = (bus.i_d[WIDTH-1:WIDTH-2] != 2'b00);
    assign w_accept  = bus.i_start && (r_state == S_IDLE || r_state == S_DONE);

    assign w_idx  = bus.i_d[WIDTH-1 -: SEED_BITS];
    assign w_t    = bus.i_d[WIDTH-1-SEED_BITS -: TB];
    assign w_drop = (P+TB)'(w_seed_dl[w_idx]) * (P+TB)'(w_t);
    assign w_x0p  = w_seed_a[w_idx] - (P+2)'(w_drop >> TB);
    assign w_x0   = {w_x0p, {(F-P){1'b0}}};

    // x <= x * (3 - d*x*x) / 2, every product truncated back to U2.F
    assign w_p_dx  = PW'(r_d) * PW'(r_x);
    assign w_dx    = IW'(w_p_dx >> WIDTH);
    assign w_p_dxx = PW'(w_dx) * PW'(r_x);
    assign w_dxx   = IW'(w_p_dxx >> F);
    assign w_h     = (IW'(3) << F) - w_dxx;
    assign w_p_xh  = PW'(r_x) * PW'(w_h);
    assign w_xn    = IW'(w_p_xh >> (F + 1));

    // Result with two guard bits below the output lsb; only d*x can reach 1.0
    assign w_g0 = w_p_dx >> (F - 2);
    always_comb begin
        w_g   = r_mode ? r_x[IW-1:2] : w_g0[WIDTH+1:0];
        w_ovf = !r_mode && (|w_g0[PW-1:WIDTH+2]);
    end

`ifdef ROOT_NEWTON_ROUND_EN
    logic [WIDTH+2:0] w_r;
    assign w_r = {1'b0, w_g} + (WIDTH+3)'(2);
    assign w_q = (w_ovf || w_r[WIDTH+2]) ? '1 : WIDTH'(w_r >> 2);
`else
    assign w_q = w_ovf ? '1 : WIDTH'(w_g >> 2);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.i_start) w_next = w_inrange ? S_ITER : S_DONE;
            S_ITER:         if (r_count == 3'(ITERS - 1)) w_next = S_FINAL;
            S_FINAL:        w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy  = (r_state == S_ITER) || (r_state == S_FINAL);
        bus.o_ready = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_d     <= '0;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_q     <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_d     <= bus.i_d;
            r_mode  <= bus.i_mode;
            r_x     <= w_x0;
            r_q     <= '0;
            r_err   <= !w_inrange;
            r_count <= '0;
        end else if (r_state == S_ITER) begin
            r_x     <= w_xn;
            r_count <= r_count + 3'd1;
        end else if (r_state == S_FINAL) begin
            r_q     <= w_q;
        end
    end

    assign bus.o_q     = r_q;
    assign bus.o_err   = r_err;
    assign bus.o_count = r_count;
endmodule
